// File: rtl/wave_meter.sv
// wave_meter: measures period (clock cycles) and per-period min/max of a 6-bit
// sampled waveform, using an adaptive threshold with hysteresis for edge detection.
module wave_meter #(
  parameter int CNT_W    = 27,
  parameter int HYST     = 4,
  parameter int THR_INIT = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       din,
  output logic [CNT_W-1:0] period,
  output logic [5:0]       vmin,
  output logic [5:0]       vmax,
  output logic             valid,
  output logic             no_signal
);

  typedef enum logic [1:0] {
    WAIT_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    RUN_HIGH  = 2'd2,
    RUN_LOW   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [6:0]       HYST_V    = 7'(HYST);
  localparam logic [6:0]       SPAN_MIN  = 7'(2 * HYST);
  localparam logic [6:0]       LEVEL_MAX = 7'd63;

  state_t           state_r;
  state_t           state_nxt_s;
  state_t           state_fsm_s;
  logic [5:0]       din_q_r;
  logic [5:0]       thr_r;
  logic [5:0]       run_min_r;
  logic [5:0]       run_max_r;
  logic [CNT_W-1:0] cnt_r;
  logic [6:0]       thr_sum_s;
  logic [6:0]       lo_s;
  logic [6:0]       hi_s;
  logic [6:0]       span_s;
  logic [6:0]       mid_s;
  logic             arm_s;
  logic             trig_s;
  logic             timeout_s;
  logic             seed_s;
  logic             meas_s;
  logic             cnt_clr_s;
  logic             running_s;

  // Hysteresis band around the current threshold, clamped to the 0..63 sample range.
  always_comb begin
    thr_sum_s = {1'b0, thr_r} + HYST_V;
    if (thr_sum_s > LEVEL_MAX) begin
      hi_s = LEVEL_MAX;
    end else begin
      hi_s = thr_sum_s;
    end
    if ({1'b0, thr_r} >= HYST_V) begin
      lo_s = {1'b0, thr_r} - HYST_V;
    end else begin
      lo_s = 7'd0;
    end
  end

  assign arm_s     = ({1'b0, din_q_r} <= lo_s);
  assign trig_s    = ({1'b0, din_q_r} >= hi_s);
  assign timeout_s = (cnt_r == CNT_MAX);
  assign span_s    = {1'b0, run_max_r} - {1'b0, run_min_r};
  assign mid_s     = ({1'b0, run_max_r} + {1'b0, run_min_r} + 7'd1) >> 1;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= WAIT_LOW;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; a saturated counter overrides any crossing seen in the same cycle.
  always_comb begin
    state_fsm_s = state_r;
    case (state_r)
      WAIT_LOW:  if (arm_s)  state_fsm_s = WAIT_HIGH; else state_fsm_s = WAIT_LOW;
      WAIT_HIGH: if (trig_s) state_fsm_s = RUN_HIGH;  else state_fsm_s = WAIT_HIGH;
      RUN_HIGH:  if (arm_s)  state_fsm_s = RUN_LOW;   else state_fsm_s = RUN_HIGH;
      RUN_LOW:   if (trig_s) state_fsm_s = RUN_HIGH;  else state_fsm_s = RUN_LOW;
      default:   state_fsm_s = WAIT_LOW;
    endcase
    if (timeout_s) begin
      state_nxt_s = WAIT_LOW;
    end else begin
      state_nxt_s = state_fsm_s;
    end
  end

  // Per-state datapath controls.
  always_comb begin
    seed_s    = 1'b0;
    meas_s    = 1'b0;
    cnt_clr_s = 1'b0;
    running_s = 1'b0;
    case (state_r)
      WAIT_LOW:  cnt_clr_s = arm_s;
      WAIT_HIGH: seed_s = trig_s;
      RUN_HIGH:  running_s = 1'b1;
      RUN_LOW: begin
        running_s = 1'b1;
        seed_s    = trig_s;
        meas_s    = trig_s;
      end
      default: begin
        seed_s    = 1'b0;
        meas_s    = 1'b0;
        cnt_clr_s = 1'b0;
        running_s = 1'b0;
      end
    endcase
  end

  // Sample register, period counter, running extremes, threshold and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      din_q_r   <= 6'd0;
      thr_r     <= 6'(THR_INIT);
      cnt_r     <= CNT_ZERO;
      run_min_r <= 6'd0;
      run_max_r <= 6'd0;
      period    <= CNT_ZERO;
      vmin      <= 6'd0;
      vmax      <= 6'd0;
      valid     <= 1'b0;
      no_signal <= 1'b0;
    end else begin
      din_q_r <= din;
      valid   <= 1'b0;
      if (timeout_s) begin
        cnt_r     <= CNT_ZERO;
        no_signal <= 1'b1;
      end else begin
        if (seed_s) begin
          cnt_r <= CNT_ONE;
        end else if (cnt_clr_s) begin
          cnt_r <= CNT_ZERO;
        end else begin
          cnt_r <= cnt_r + CNT_ONE;
        end
        // The trigger sample opens the next window, so it re-seeds instead of updating.
        if (seed_s) begin
          run_min_r <= din_q_r;
          run_max_r <= din_q_r;
        end else if (running_s) begin
          if (din_q_r < run_min_r) run_min_r <= din_q_r;
          if (din_q_r > run_max_r) run_max_r <= din_q_r;
        end
        if (meas_s) begin
          period    <= cnt_r;
          vmin      <= run_min_r;
          vmax      <= run_max_r;
          valid     <= 1'b1;
          no_signal <= 1'b0;
          if (span_s > SPAN_MIN) thr_r <= mid_s[5:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_wave_meter.sv
// Testbench for wave_meter: timestamp-based reference model feeds a scoreboard queue;
// an independent monitor checks every valid pulse and every no_signal assertion.
module tb_wave_meter;
  localparam int CNT_W    = 10;
  localparam int HYST     = 4;
  localparam int THR_INIT = 32;
  localparam int CMAX     = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic [5:0]       din;
  logic [CNT_W-1:0] period;
  logic [5:0]       vmin;
  logic [5:0]       vmax;
  logic             valid;
  logic             no_signal;

  wave_meter #(.CNT_W(CNT_W), .HYST(HYST), .THR_INIT(THR_INIT)) dut (
    .clk(clk), .rst(rst), .din(din), .period(period),
    .vmin(vmin), .vmax(vmax), .valid(valid), .no_signal(no_signal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit is_to;
    int per;
    int mn;
    int mx;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  // Reference model: absolute decision timestamps, sample window as a queue.
  int  m_n = 0;
  int  m_t0 = 0;
  int  m_w0 = 0;
  int  m_dq = 0;
  int  m_thr = THR_INIT;
  bit  m_armed = 1'b0;
  bit  m_timing = 1'b0;
  bit  m_ns = 1'b0;
  int  m_win[$];

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, got, want, $time);
    end
  endtask

  task automatic model_step(input int d, input bit r);
    int cnt, lo, hi, mn, mx;
    ev_t e;
    if (r) begin
      m_dq = 0; m_thr = THR_INIT; m_armed = 1'b0; m_timing = 1'b0; m_ns = 1'b0;
      m_win.delete();
      m_w0 = m_n + 1;
      m_n++;
      return;
    end
    cnt = m_timing ? (m_n - m_t0) : (m_n - m_w0);
    lo  = (m_thr - HYST < 0) ? 0 : m_thr - HYST;
    hi  = (m_thr + HYST > 63) ? 63 : m_thr + HYST;
    if (cnt == CMAX) begin
      if (!m_ns) begin
        e.is_to = 1'b1; e.per = 0; e.mn = 0; e.mx = 0;
        exp_q.push_back(e);
      end
      m_ns = 1'b1; m_armed = 1'b0; m_timing = 1'b0;
      m_win.delete();
      m_w0 = m_n + 1;
    end else if (m_armed && m_dq >= hi) begin
      if (m_timing) begin
        mn = 63; mx = 0;
        foreach (m_win[i]) begin
          if (m_win[i] < mn) mn = m_win[i];
          if (m_win[i] > mx) mx = m_win[i];
        end
        e.is_to = 1'b0; e.per = m_n - m_t0; e.mn = mn; e.mx = mx;
        exp_q.push_back(e);
        m_ns = 1'b0;
        if (mx - mn > 2 * HYST) m_thr = (mx + mn + 1) / 2;
      end
      m_timing = 1'b1; m_armed = 1'b0; m_t0 = m_n;
      m_win.delete();
      m_win.push_back(m_dq);
    end else begin
      if (!m_armed && m_dq <= lo) begin
        m_armed = 1'b1;
        if (!m_timing) m_w0 = m_n + 1;
      end
      if (m_timing) m_win.push_back(m_dq);
    end
    m_dq = d;
    m_n++;
  endtask

  task automatic drive(input int v, input bit r);
    @(negedge clk);
    din = 6'(v);
    rst = r;
    model_step(v, r);
  endtask

  task automatic sq(input int a, input int b, input int half, input int reps);
    for (int k = 0; k < reps; k++) begin
      for (int i = 0; i < half; i++) drive(a, 1'b0);
      for (int i = 0; i < half; i++) drive(b, 1'b0);
    end
  endtask

  task automatic saw(input int a, input int b, input int reps);
    for (int k = 0; k < reps; k++)
      for (int v = a; v <= b; v++) drive(v, 1'b0);
  endtask

  task automatic check_zero();
    @(posedge clk);
    #1;
    chk("rst_period", int'(period), 0);
    chk("rst_vmin", int'(vmin), 0);
    chk("rst_vmax", int'(vmax), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_no_signal", int'(no_signal), 0);
  endtask

  // Monitor: pops one expected event per valid pulse or per rising no_signal.
  bit valid_prev = 1'b0;
  bit ns_prev = 1'b0;
  always begin
    ev_t e;
    @(posedge clk);
    #1;
    if (valid) begin
      chk("valid_width", int'(valid_prev), 0);
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("event_kind_valid", int'(e.is_to), 0);
        chk("period", int'(period), e.per);
        chk("vmin", int'(vmin), e.mn);
        chk("vmax", int'(vmax), e.mx);
        chk("no_signal_on_valid", int'(no_signal), 0);
      end
    end
    if (no_signal && !ns_prev) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_no_signal", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("event_kind_timeout", int'(e.is_to), 1);
      end
    end
    valid_prev = valid;
    ns_prev    = no_signal;
  end

  initial begin
    int a, b;
    rst = 1'b1;
    din = 6'd0;
    drive(0, 1'b1);
    drive(0, 1'b1);
    check_zero();

    // Square wave 0/63, period 100.
    sq(0, 63, 50, 5);

    // Triangle, step 1 per 4 clocks, period 504.
    for (int k = 0; k < 3; k++) begin
      for (int v = 0; v <= 62; v++) for (int j = 0; j < 4; j++) drive(v, 1'b0);
      for (int v = 63; v >= 1; v--) for (int j = 0; j < 4; j++) drive(v, 1'b0);
    end

    // Chatter around each edge of a 0/63 square, period 200.
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 80; i++) drive(0, 1'b0);
      for (int i = 0; i < 20; i++) drive((i % 2) ? 33 : 31, 1'b0);
      for (int i = 0; i < 80; i++) drive(63, 1'b0);
      for (int i = 0; i < 20; i++) drive((i % 2) ? 33 : 31, 1'b0);
    end

    // Low amplitude until timeout, then recovery on a square wave.
    sq(0, 63, 50, 2);
    for (int i = 0; i < 1100; i++) drive($urandom_range(30, 34), 1'b0);
    sq(0, 63, 50, 3);

    // Reset midway through the third period.
    sq(0, 63, 50, 2);
    for (int i = 0; i < 25; i++) drive(0, 1'b0);
    drive(0, 1'b1);
    check_zero();
    sq(0, 63, 50, 4);

    // Period beyond counter range: timeout while timing.
    sq(0, 63, 600, 2);
    sq(0, 63, 50, 3);

    // Walk the threshold up, then sawtooth 40..60.
    sq(20, 63, 30, 3);
    sq(35, 63, 30, 3);
    saw(40, 60, 8);

    // Randomised segments.
    for (int s = 0; s < 40; s++) begin
      case ($urandom_range(0, 4))
        0: begin
          a = $urandom_range(0, 63);
          b = $urandom_range(0, 63);
          sq(a, b, $urandom_range(1, 40), $urandom_range(3, 6));
        end
        1: for (int i = 0; i < int'($urandom_range(50, 300)); i++) drive($urandom_range(0, 63), 1'b0);
        2: saw($urandom_range(0, 30), $urandom_range(33, 63), 3);
        3: drive($urandom_range(0, 63), 1'b1);
        default: sq(0, 63, $urandom_range(2, 30), 3);
      endcase
    end

    for (int i = 0; i < 6; i++) drive(0, 1'b0);
    @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wave_meter.md
# wave_meter

Measures an incoming 6-bit sampled waveform, the same 64-level sample format our waveform generators drive onto the 6-pin DAC bus, and reports its period in clock cycles plus its minimum and maximum sample per period. It sits on the capture side of the function-generator board as a self-test and loopback checker: generator output → ADC/pin bus → this block. The reported period is directly comparable to the cycles-per-period the generator was programmed with. Edge detection uses an adaptive threshold with hysteresis, so triangle, sawtooth and square shapes all measure cleanly.

## Interface
- CNT_W, 27, width of the period counter and `period` output; the bench uses 10 to make timeouts reachable.
- HYST, 4, hysteresis half-width in LSBs; legal range 1..15.
- THR_INIT, 32, threshold used after reset until the first threshold update.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- din  in  6  waveform sample, one per clock, unsigned.
- period  out  CNT_W  cycles between the last two trigger events; reset 0.
- vmin  out  6  minimum sample over the last measured period; reset 0.
- vmax  out  6  maximum sample over the last measured period; reset 0.
- valid  out  1  one-cycle pulse when period/vmin/vmax update; reset 0.
- no_signal  out  1  sticky timeout flag; cleared by the next valid measurement; reset 0.

## Operation
- `din` is registered into `din_q`. All decisions use `din_q`.
- Derived levels:
  - lo = max(thr − HYST, 0); hi = min(thr + HYST, 63).
  - arm when din_q ≤ lo.
  - trigger (rising crossing) when armed and din_q ≥ hi.
- FSM states:
  - WAIT_LOW: after reset or timeout. din_q ≤ lo → WAIT_HIGH.
  - WAIT_HIGH: armed, not yet timing. Trigger → RUN_HIGH; cnt ← 1; run_min/run_max ← din_q. No `valid` on this first trigger.
  - RUN_HIGH: timing, disarmed. din_q ≤ lo → RUN_LOW.
  - RUN_LOW: timing, armed. On trigger:
    - period ← cnt; vmin ← run_min; vmax ← run_max.
    - valid ← 1; no_signal ← 0.
    - cnt ← 1; run_min/run_max ← din_q.
    - Next state RUN_HIGH.
- Measured quantities:
  - For triggers at din_q cycles t0 and t1, period = t1 − t0.
  - vmin/vmax cover the samples in t0..t1−1, inclusive of the t0 trigger sample.
- Counter: cnt increments every cycle in all states.
  - In WAIT_LOW/WAIT_HIGH, cnt starts from 0 on entry.
  - cnt saturates at 2^CNT_W − 1. Reaching saturation in any state sets no_signal ← 1, forces WAIT_LOW and resets cnt to 0.
  - No `valid` is produced on timeout; period/vmin/vmax hold their last values.
- Threshold update, evaluated on each `valid`:
  - if run_max − run_min > 2·HYST, thr ← (run_max + run_min + 1) >> 1, computed in 7 bits.
  - otherwise thr holds its current value.
- Running min/max: updated every RUN cycle, except the trigger cycle, where they are re-seeded instead.
- Reset mid-operation: all state is cleared in one cycle, including thr ← THR_INIT, and the FSM goes to WAIT_LOW. The next `valid` needs two fresh triggers.

## Timing
- Latency:
  - `din` sampled at edge e → din_q valid after e.
  - The trigger decision uses din_q during cycle e..e+1.
  - period/vmin/vmax/valid/no_signal update at edge e+1.
  - Total: 2 edges from `din` to `valid`.
- Output behaviour:
  - `valid` is high for exactly one cycle per measurement.
  - Outputs are stable until the next `valid` or reset.
- Priority: rst > timeout > trigger > arm.
  - A trigger on the same cycle cnt saturates counts as a timeout.
- Trigger spacing: the minimum legal period is 2 (arm and trigger on alternate cycles), so back-to-back `valid` pulses are impossible.
- Throughput: one sample per clock, no stalls, no input handshake.

## Test plan
- Square wave, 50 cycles of 0 then 50 of 63, repeated 5×:
  - first `valid` at the second rising edge;
  - then period=100, vmin=0, vmax=63 on every valid;
  - thr becomes 32.
- Triangle 0→63→0, step 1 per 4 clocks (period 504):
  - period=504, vmin=0, vmax=63 each valid;
  - valid is 1 cycle wide, 2 edges after the din value that crosses 36.
- Chatter: din toggles 31/33 for 20 cycles around each edge of a 0/63 square wave, period 200:
  - exactly one valid per period;
  - period=200.
- Low amplitude: din swings 30..34 with thr=32, HYST=4:
  - never arms, no valid;
  - with CNT_W=10, no_signal=1 at cycle 1023.
  - Then apply the square wave: no_signal clears on the first valid.
- Reset mid-period: assert rst for 1 cycle midway through the 3rd period of the square wave:
  - all outputs 0 the next cycle;
  - no valid until 2 new triggers;
  - then period=100.
- Threshold adaptation: sawtooth 40..60 (ramp +1/clk, drop to 40):
  - first valid period=21, vmin=40, vmax=60;
  - thr updates to 50;
  - measurements remain period=21.
